// File: rtl/demux.sv
// Two-channel TDM demultiplexer: splits an alternating ch0/ch1 slot stream into two registered outputs.
// Latency: one clock from acceptance of a slot's final beat to o0/o1 and v0/v1.
// Backpressure: none; beats are accepted whenever din_valid is high, and gaps simply stretch the slot.
module demux #(
    parameter int WIDTH    = 1,
    parameter int SLOT_LEN = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] o0,
    output logic [WIDTH-1:0] o1,
    output logic             v0,
    output logic             v1,
    output logic             switch,
    output logic             locked,
    output logic             sync_err
);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        SLOT0 = 2'd1,
        SLOT1 = 2'd2
    } state_t;

    // Index of the beat that closes a slot and gets captured.
    localparam logic [7:0] LAST = 8'(SLOT_LEN - 1);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] o0_q, o0_d;
    logic [WIDTH-1:0] o1_q, o1_d;
    logic             v0_q, v0_d;
    logic             v1_q, v1_d;
    logic             err_q, err_d;

    // Beat classification flags used by the next-state logic.
    logic             start_slot;
    logic             advance;

    // Next-state logic: classify each valid beat, then apply realign/advance/drop.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        o0_d       = o0_q;
        o1_d       = o1_q;
        v0_d       = 1'b0;
        v1_d       = 1'b0;
        err_d      = 1'b0;
        start_slot = 1'b0;
        advance    = 1'b0;

        if (din_valid) begin
            unique case (state_q)
                HUNT: begin
                    // Unsynced beats are dropped until a sync marker shows up.
                    start_slot = frame_sync;
                end
                SLOT0: begin
                    if (cnt_q == 8'd0) begin
                        if (frame_sync) begin
                            start_slot = 1'b1;
                        end else begin
                            // Expected marker missing: lose lock and drop the beat.
                            err_d   = 1'b1;
                            state_d = HUNT;
                            cnt_d   = 8'd0;
                        end
                    end else if (frame_sync) begin
                        err_d      = 1'b1;
                        start_slot = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
                SLOT1: begin
                    // A marker anywhere in SLOT1 is misplaced; realignment beats capture.
                    if (frame_sync) begin
                        err_d      = 1'b1;
                        start_slot = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
                default: begin
                    state_d = HUNT;
                    cnt_d   = 8'd0;
                end
            endcase
        end

        if (start_slot) begin
            // This beat is SLOT0 beat 0; a one-beat slot completes right away.
            if (LAST == 8'd0) begin
                o0_d    = din;
                v0_d    = 1'b1;
                state_d = SLOT1;
                cnt_d   = 8'd0;
            end else begin
                state_d = SLOT0;
                cnt_d   = 8'd1;
            end
        end else if (advance) begin
            if (cnt_q == LAST) begin
                cnt_d = 8'd0;
                if (state_q == SLOT0) begin
                    o0_d    = din;
                    v0_d    = 1'b1;
                    state_d = SLOT1;
                end else begin
                    o1_d    = din;
                    v1_d    = 1'b1;
                    state_d = SLOT0;
                end
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // State, counter and output registers; reset clears everything including captured data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= HUNT;
            cnt_q   <= 8'd0;
            o0_q    <= '0;
            o1_q    <= '0;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o0_q    <= o0_d;
            o1_q    <= o1_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            err_q   <= err_d;
        end
    end

    assign o0       = o0_q;
    assign o1       = o1_q;
    assign v0       = v0_q;
    assign v1       = v1_q;
    assign sync_err = err_q;
    assign switch   = (state_q == SLOT1);
    assign locked   = (state_q != HUNT);

endmodule

// File: tb/tb_demux.sv
// Directed bench for demux: SLOT_LEN=4/WIDTH=1 instance plus SLOT_LEN=1/WIDTH=8 instance.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// All expected values are hand-derived constants.
module tb_demux;

    logic       clock = 1'b0;
    logic       reset = 1'b1;

    logic       a_din = 1'b0, a_vld = 1'b0, a_sync = 1'b0;
    logic       a_o0, a_o1, a_v0, a_v1, a_sw, a_lk, a_err;

    logic [7:0] b_din = 8'h00;
    logic       b_vld = 1'b0, b_sync = 1'b0;
    logic [7:0] b_o0, b_o1;
    logic       b_v0, b_v1, b_sw, b_lk, b_err;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    demux #(.WIDTH(1), .SLOT_LEN(4)) dut_a (
        .clock(clock), .reset(reset), .din(a_din), .din_valid(a_vld), .frame_sync(a_sync),
        .o0(a_o0), .o1(a_o1), .v0(a_v0), .v1(a_v1), .switch(a_sw), .locked(a_lk), .sync_err(a_err)
    );

    demux #(.WIDTH(8), .SLOT_LEN(1)) dut_b (
        .clock(clock), .reset(reset), .din(b_din), .din_valid(b_vld), .frame_sync(b_sync),
        .o0(b_o0), .o1(b_o1), .v0(b_v0), .v1(b_v1), .switch(b_sw), .locked(b_lk), .sync_err(b_err)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat_a(input logic s, input logic d);
        @(negedge clock);
        a_vld = 1'b1; a_sync = s; a_din = d;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_a();
        @(negedge clock);
        a_vld = 1'b0; a_sync = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic beat_b(input logic s, input logic [7:0] d);
        @(negedge clock);
        b_vld = 1'b1; b_sync = s; b_din = d;
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge clock);
        #1;
        chk("rst_o0", 8'(a_o0), 8'h0);
        chk("rst_o1", 8'(a_o1), 8'h0);
        chk("rst_v0", 8'(a_v0), 8'h0);
        chk("rst_sw", 8'(a_sw), 8'h0);
        chk("rst_lk", 8'(a_lk), 8'h0);
        chk("rst_err", 8'(a_err), 8'h0);
        chk("rst_b_o0", b_o0, 8'h00);
        @(negedge clock);
        reset = 1'b0;

        // Fully valid stream: ch0 = 0,0,0,1 (sync on first), ch1 = 1,1,1,0
        beat_a(1'b1, 1'b0);
        chk("t1_lock_b0", 8'(a_lk), 8'h1);
        chk("t1_sw_b0", 8'(a_sw), 8'h0);
        beat_a(1'b0, 1'b0);
        beat_a(1'b0, 1'b0);
        chk("t1_v0_early", 8'(a_v0), 8'h0);
        beat_a(1'b0, 1'b1);
        chk("t1_v0", 8'(a_v0), 8'h1);
        chk("t1_o0", 8'(a_o0), 8'h1);
        chk("t1_sw_b4", 8'(a_sw), 8'h1);
        beat_a(1'b0, 1'b1);
        chk("t1_v0_drop", 8'(a_v0), 8'h0);
        beat_a(1'b0, 1'b1);
        beat_a(1'b0, 1'b1);
        chk("t1_sw_b7", 8'(a_sw), 8'h1);
        beat_a(1'b0, 1'b0);
        chk("t1_v1", 8'(a_v1), 8'h1);
        chk("t1_o1", 8'(a_o1), 8'h0);
        chk("t1_sw_end", 8'(a_sw), 8'h0);
        chk("t1_err", 8'(a_err), 8'h0);

        // Same stream with a gap after every beat
        beat_a(1'b1, 1'b0); idle_a();
        beat_a(1'b0, 1'b0); idle_a();
        beat_a(1'b0, 1'b0); idle_a();
        chk("t2_v0_gap", 8'(a_v0), 8'h0);
        beat_a(1'b0, 1'b1);
        chk("t2_v0", 8'(a_v0), 8'h1);
        chk("t2_o0", 8'(a_o0), 8'h1);
        idle_a();
        chk("t2_v0_once", 8'(a_v0), 8'h0);
        chk("t2_sw_gap", 8'(a_sw), 8'h1);
        beat_a(1'b0, 1'b1); idle_a();
        beat_a(1'b0, 1'b1); idle_a();
        beat_a(1'b0, 1'b1); idle_a();
        chk("t2_v1_gap", 8'(a_v1), 8'h0);
        beat_a(1'b0, 1'b0);
        chk("t2_v1", 8'(a_v1), 8'h1);
        chk("t2_o1", 8'(a_o1), 8'h0);
        chk("t2_err", 8'(a_err), 8'h0);

        // Missing sync on SLOT0 beat 0 -> lose lock, then relock
        beat_a(1'b0, 1'b1);
        chk("t3_err", 8'(a_err), 8'h1);
        chk("t3_unlock", 8'(a_lk), 8'h0);
        chk("t3_v0_none", 8'(a_v0), 8'h0);
        beat_a(1'b0, 1'b1);
        chk("t3_err_once", 8'(a_err), 8'h0);
        chk("t3_hunt", 8'(a_lk), 8'h0);
        beat_a(1'b1, 1'b1);
        chk("t3_relock", 8'(a_lk), 8'h1);
        beat_a(1'b0, 1'b0);
        beat_a(1'b0, 1'b0);
        beat_a(1'b0, 1'b0);
        chk("t3_v0", 8'(a_v0), 8'h1);
        chk("t3_o0", 8'(a_o0), 8'h0);

        // Misplaced sync on SLOT1 beat 3 -> realign, no ch1 capture
        beat_a(1'b0, 1'b1);
        beat_a(1'b0, 1'b1);
        beat_a(1'b0, 1'b1);
        beat_a(1'b1, 1'b1);
        chk("t4_err", 8'(a_err), 8'h1);
        chk("t4_no_v1", 8'(a_v1), 8'h0);
        chk("t4_o1_hold", 8'(a_o1), 8'h0);
        chk("t4_sw", 8'(a_sw), 8'h0);
        chk("t4_lock", 8'(a_lk), 8'h1);
        beat_a(1'b0, 1'b1);
        beat_a(1'b0, 1'b1);
        chk("t4_v0_early", 8'(a_v0), 8'h0);
        beat_a(1'b0, 1'b1);
        chk("t4_v0", 8'(a_v0), 8'h1);
        chk("t4_o0", 8'(a_o0), 8'h1);

        // Reset mid-SLOT1 with o0=1
        beat_a(1'b0, 1'b0);
        chk("t5_sw_pre", 8'(a_sw), 8'h1);
        @(negedge clock);
        a_vld = 1'b0;
        reset = 1'b1;
        #1;
        chk("t5_o0_async", 8'(a_o0), 8'h0);
        chk("t5_sw_async", 8'(a_sw), 8'h0);
        chk("t5_lk_async", 8'(a_lk), 8'h0);
        @(negedge clock);
        reset = 1'b0;
        beat_a(1'b0, 1'b1);
        beat_a(1'b0, 1'b1);
        beat_a(1'b0, 1'b1);
        beat_a(1'b0, 1'b1);
        chk("t5_ignored_lk", 8'(a_lk), 8'h0);
        chk("t5_ignored_v0", 8'(a_v0), 8'h0);
        chk("t5_ignored_o0", 8'(a_o0), 8'h0);
        idle_a();

        // SLOT_LEN=1, WIDTH=8: A5(sync), 3C, 11(sync)
        beat_b(1'b1, 8'hA5);
        chk("t6_v0_a", 8'(b_v0), 8'h1);
        chk("t6_o0_a", b_o0, 8'hA5);
        chk("t6_v1_a", 8'(b_v1), 8'h0);
        chk("t6_sw_a", 8'(b_sw), 8'h1);
        beat_b(1'b0, 8'h3C);
        chk("t6_v1_b", 8'(b_v1), 8'h1);
        chk("t6_o1_b", b_o1, 8'h3C);
        chk("t6_v0_b", 8'(b_v0), 8'h0);
        beat_b(1'b1, 8'h11);
        chk("t6_v0_c", 8'(b_v0), 8'h1);
        chk("t6_o0_c", b_o0, 8'h11);
        chk("t6_v1_c", 8'(b_v1), 8'h0);
        chk("t6_err", 8'(b_err), 8'h0);
        chk("t6_lock", 8'(b_lk), 8'h1);
        @(negedge clock);
        b_vld = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux.md
# demux

Two-channel time-division demultiplexer: the receive end of the 2:1 `mux` path. It takes a single time-multiplexed data stream in which channel 0 and channel 1 alternate in fixed-length slots, with a frame-sync marker on the first beat of each channel-0 slot. It separates the stream back into two registered channel outputs, each with a one-cycle update strobe. It tracks slot position with a beat counter and a lock state machine, and reports sync errors.

## Interface
Parameters:
- `WIDTH`, default 1: data width per channel.
- `SLOT_LEN`, default 4: accepted beats per slot, range 1..255.

Ports:
- `clock` input 1: single clock; all logic is on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `din` input WIDTH: multiplexed data beat.
- `din_valid` input 1: `din` is valid this cycle; beats without valid are ignored and do not advance the counter.
- `frame_sync` input 1: qualified by `din_valid`; marks beat 0 of a channel-0 slot.
- `o0` output WIDTH: last captured channel-0 value.
- `o1` output WIDTH: last captured channel-1 value.
- `v0` output 1: one-cycle pulse when `o0` updates.
- `v1` output 1: one-cycle pulse when `o1` updates.
- `switch` output 1: slot currently being received (0 = channel 0, 1 = channel 1); this is the receive-side equivalent of the mux select.
- `locked` output 1: alignment established.
- `sync_err` output 1: one-cycle pulse on an alignment violation.

## Operation
- States:
  - HUNT: waiting for the first sync.
  - SLOT0: receiving channel 0.
  - SLOT1: receiving channel 1.
- Beat counter `cnt` is 8 bits wide and counts 0..SLOT_LEN-1. It advances only on a valid beat and wraps to 0 at the end of each slot.
- HUNT:
  - Valid beats without sync are discarded.
  - A valid beat with `frame_sync` becomes beat 0 of SLOT0: cnt becomes 1 (or the slot completes immediately if SLOT_LEN=1), and `locked` is set.
- SLOT0 and SLOT1: the last beat of a slot (cnt = SLOT_LEN-1) is the captured value.
  - In SLOT0, `din` is captured into `o0`, `v0` pulses, and the state moves to SLOT1.
  - In SLOT1, `din` is captured into `o1`, `v1` pulses, and the state moves to SLOT0.
- Sync checking while locked:
  - `frame_sync` on beat 0 of SLOT0 is expected.
  - `frame_sync` on any other beat: `sync_err` pulses, and that beat is treated as SLOT0 beat 0 (realign, stay locked, no capture from the aborted slot).
  - A missing `frame_sync` on SLOT0 beat 0: `sync_err` pulses, the state goes to HUNT, `locked` clears, and the beat is discarded.
- `switch` equals 1 in SLOT1 and 0 otherwise, including HUNT.
- `o0` and `o1` hold their value until their next capture. They are not cleared on loss of lock.
- Simultaneous events:
  - With SLOT_LEN=1, a sync beat in HUNT enters SLOT0 and captures `o0` on the same edge.
  - If a misplaced sync lands on the last beat of SLOT1, realignment wins and `o1` is not captured.

## Timing
- Reset values: state HUNT, cnt 0, `o0`=0, `o1`=0, `v0`=0, `v1`=0, `switch`=0, `locked`=0, `sync_err`=0.
- Latency: `o0`/`o1` and `v0`/`v1` are valid in the cycle after the edge that accepts the slot's final beat, i.e. one clock of latency.
- `v0`, `v1` and `sync_err` are high for exactly one cycle per event.
- `switch` and `locked` are registered and change on the edge that accepts the triggering beat.
- Gaps in `din_valid` stretch slots arbitrarily; no timeout applies.
- Reset asserted mid-slot forces all registers to their reset values immediately. After release, the block returns to HUNT and needs a new sync.

## Test plan
- SLOT_LEN=4, WIDTH=1; stream [sync,0,0,0,1] for ch0 then [1,1,1,0] for ch1, fully valid -> `v0` pulse with `o0`=1 one cycle after beat 3, `v1` pulse with `o1`=0 one cycle after beat 7, `switch` high for beats 4..7, `locked`=1 from beat 0.
- Same stream with `din_valid` low every other cycle -> identical `o0`/`o1` values; strobes are delayed by the gaps; no `sync_err`.
- Locked; `frame_sync` missing at the next SLOT0 beat 0 -> `sync_err` one pulse, `locked`=0, state HUNT; a following sync relocks and the next `o0` is correct.
- Locked; `frame_sync` asserted on SLOT1 beat 3 -> `sync_err` pulse, no `v1`, `switch`=0, next capture is `o0` after 3 more beats.
- Reset pulsed mid-SLOT1 with `o0`=1 -> all outputs 0 asynchronously; beats after release are ignored until sync.
- SLOT_LEN=1, WIDTH=8; beats 0xA5 with sync, 0x3C, 0x11 with sync -> `o0`=0xA5, `o1`=0x3C, `o0`=0x11, strobes alternating on consecutive cycles.
